mips32_mem_responder: RTL and testbench

Single-clock memory responder serving the MIPS32 core's load/store and fetch traffic through a valid/ready request/response handshake. It holds a word-addressed 32-bit memory with a programmable number of wait states, so the pipeline's memory side can be exercised against realistic latency rather than an ideal zero-delay array. It sits between the core's memory-stage master port and the backing storage. Benches preload it the same way the core's memory is preloaded.

---
 rtl/mips32_pkg.sv | 40 ++++
 rtl/mips32_mem_responder_if.sv | 29 ++
 rtl/mips32_sram_array.sv | 33 +++
 rtl/mips32_mem_responder.sv | 139 +++++++++++++
 tb/tb_mips32_mem_responder.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: word width, responder state encoding, opcode constants.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mips32_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    // Memory responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_t;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef enum logic [1:0] {
        ITYPE_R = 2'd0,
        ITYPE_I = 2'd1,
        ITYPE_J = 2'd2
    } instr_type_t;

    function automatic instr_type_t instr_type(input logic [5:0] opcode);
        if (opcode == OP_RTYPE) begin
            return ITYPE_R;
        end else if (opcode == OP_J) begin
            return ITYPE_J;
        end else begin
            return ITYPE_I;
        end
    endfunction

endpackage

// File: rtl/mips32_mem_responder_if.sv
// Request/response bus between the core memory stage and the memory responder.
// Latency: none (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface mips32_mem_responder_if #(
    parameter int ADDR_W = 10
);
    import mips32_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    word_t             req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    word_t             rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mips32_sram_array.sv
// Single-port synchronous word array, one read or one write per enabled edge.
// Latency: read data registered, valid the cycle after the enabled edge.
// Backpressure: none; the caller sequences accesses.
module mips32_sram_array
    import mips32_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int IDX_W     = 10,
    parameter     INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  word_t            wdata,
    output word_t            rdata
);

    // Not cleared by reset; benches preload it hierarchically.
    word_t mem [0:DEPTH-1];

    // One access per enabled edge: write the word, or capture it for reading
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/mips32_mem_responder.sv
// Word-addressed memory responder with WAIT_CYCLES wait states and address-range check.
// Latency: access at edge accept+WAIT_CYCLES, response valid the following cycle.
// Backpressure: req_ready only in IDLE; response held until rsp_ready.
module mips32_mem_responder
    import mips32_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips32_mem_responder_if.slave bus
);

    localparam int CNT_W = ($clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    // One extra bit so DEPTH == 2**ADDR_W is representable
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    typedef struct packed {
        logic              we;
        logic              err;
        logic [ADDR_W-1:0] addr;
        word_t             wdata;
    } req_t;

    rsp_state_t       state_q;
    rsp_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    req_t             req_q;
    req_t             req_in;
    req_t             acc_req;
    logic             accept;
    logic             access;

    logic             arr_en;
    logic             arr_we;
    logic [IDX_W-1:0] arr_idx;
    word_t            arr_wdata;
    word_t            arr_rdata;

    logic             req_ready_c;
    logic             rsp_valid_c;
    logic             rsp_err_c;
    word_t            rsp_rdata_c;

    // Incoming request with its range check resolved up front
    always_comb begin
        req_in       = '0;
        req_in.we    = bus.req_we;
        req_in.addr  = bus.req_addr;
        req_in.wdata = bus.req_wdata;
        req_in.err   = ({1'b0, bus.req_addr} >= DEPTH_X);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and array controls, decoded from state and registered request only
    always_comb begin
        accept      = (state_q == IDLE) && bus.req_valid;
        // Zero wait states: the access shares the accept edge and uses the live request
        access      = (WAIT_CYCLES == 0) ? accept : ((state_q == WAIT) && (cnt_q == '0));
        acc_req     = (WAIT_CYCLES == 0) ? req_in : req_q;
        arr_en      = access && !acc_req.err;
        arr_we      = acc_req.we;
        arr_idx     = acc_req.addr[IDX_W-1:0];
        arr_wdata   = acc_req.wdata;
        req_ready_c = (state_q == IDLE);
        rsp_valid_c = (state_q == RESP);
        rsp_err_c   = (state_q == RESP) && req_q.err;
        // Array read register only changes on an access edge, so it is stable through RESP
        rsp_rdata_c = ((state_q == RESP) && !req_q.we && !req_q.err) ? arr_rdata : '0;
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_err   = rsp_err_c;
    assign bus.rsp_rdata = rsp_rdata_c;

    // Latch the request at acceptance and run the wait-state counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            req_q <= req_in;
            cnt_q <= CNT_INIT;
        end else if ((state_q == WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    mips32_sram_array #(
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Scoreboard bench for mips32_mem_responder across three parameter sets.
// Latency: checks wait-state timing, ready occupancy and response hold.
// Backpressure: exercises rsp_ready stalls and back-to-back requests.
module tb_mips32_mem_responder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // a: default (2 wait states), b: zero wait states, c: DEPTH 512 with 1 wait state
    mips32_mem_responder_if #(.ADDR_W(10)) ifa ();
    mips32_mem_responder_if #(.ADDR_W(10)) ifb ();
    mips32_mem_responder_if #(.ADDR_W(10)) ifc ();

    mips32_mem_responder #(.ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(2), .INIT_FILE("")) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    mips32_mem_responder #(.ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(0), .INIT_FILE("")) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));
    mips32_mem_responder #(.ADDR_W(10), .DEPTH(512), .WAIT_CYCLES(1), .INIT_FILE("")) u_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc));

    int checks = 0;
    int errors = 0;

    // Expected responses {rdata, err}, one queue per responder
    logic [32:0] sb_a [$];
    logic [32:0] sb_b [$];
    logic [32:0] sb_c [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic we,
                         input logic [9:0] a, input logic [31:0] d);
        case (s)
            0: begin ifa.req_valid = v; ifa.req_we = we; ifa.req_addr = a; ifa.req_wdata = d; end
            1: begin ifb.req_valid = v; ifb.req_we = we; ifb.req_addr = a; ifb.req_wdata = d; end
            default: begin ifc.req_valid = v; ifc.req_we = we; ifc.req_addr = a; ifc.req_wdata = d; end
        endcase
    endtask

    // f: 0 req_ready, 1 rsp_valid, 2 rsp_rdata, 3 rsp_err
    function automatic logic [31:0] obs(input int s, input int f);
        logic [31:0] r;
        r = '0;
        case (s)
            0: case (f) 0: r = 32'(ifa.req_ready); 1: r = 32'(ifa.rsp_valid);
                        2: r = ifa.rsp_rdata;      default: r = 32'(ifa.rsp_err); endcase
            1: case (f) 0: r = 32'(ifb.req_ready); 1: r = 32'(ifb.rsp_valid);
                        2: r = ifb.rsp_rdata;      default: r = 32'(ifb.rsp_err); endcase
            default: case (f) 0: r = 32'(ifc.req_ready); 1: r = 32'(ifc.rsp_valid);
                        2: r = ifc.rsp_rdata;      default: r = 32'(ifc.rsp_err); endcase
        endcase
        return r;
    endfunction

    task automatic push(input int s, input logic [31:0] rd, input logic err);
        case (s)
            0: sb_a.push_back({rd, err});
            1: sb_b.push_back({rd, err});
            default: sb_c.push_back({rd, err});
        endcase
    endtask

    // Issue one request at a negedge with the responder idle; measure ready-low
    // cycles and the cycle (after acceptance) in which rsp_valid first shows.
    task automatic req(input int s, input logic we, input logic [9:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input logic eerr,
                       input int elow, input int elat, input string nm);
        int low   = 0;
        int first = -1;
        drive(s, 1'b1, we, a, d);
        push(s, erd, eerr);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) drive(s, 1'b0, we, a, d);
            if (obs(s, 1) != 0 && first < 0) first = k;
            if (obs(s, 0) != 0) break;
            low++;
        end
        chk({nm, "_ready_low"}, 32'(low), 32'(elow));
        chk({nm, "_rsp_lat"}, 32'(first), 32'(elat));
    endtask

    // Monitor: pop and compare on every response handshake
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && ifa.rsp_valid && ifa.rsp_ready) begin
            if (sb_a.size() == 0) begin
                chk("a_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb_a.pop_front();
                chk("a_rsp_rdata", ifa.rsp_rdata, e[32:1]);
                chk("a_rsp_err", 32'(ifa.rsp_err), 32'(e[0]));
            end
        end
        if (rst_n && ifb.rsp_valid && ifb.rsp_ready) begin
            if (sb_b.size() == 0) begin
                chk("b_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb_b.pop_front();
                chk("b_rsp_rdata", ifb.rsp_rdata, e[32:1]);
                chk("b_rsp_err", 32'(ifb.rsp_err), 32'(e[0]));
            end
        end
        if (rst_n && ifc.rsp_valid && ifc.rsp_ready) begin
            if (sb_c.size() == 0) begin
                chk("c_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb_c.pop_front();
                chk("c_rsp_rdata", ifc.rsp_rdata, e[32:1]);
                chk("c_rsp_err", 32'(ifc.rsp_err), 32'(e[0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 10'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 10'd0, 32'd0);
        drive(2, 1'b0, 1'b0, 10'd0, 32'd0);
        ifa.rsp_ready = 1'b1;
        ifb.rsp_ready = 1'b1;
        ifc.rsp_ready = 1'b1;

        // Preload images
        u_a.u_array.mem[120] = 32'd105;
        u_a.u_array.mem[121] = 32'd0;
        u_a.u_array.mem[7]   = 32'hfc000000;
        u_a.u_array.mem[5]   = 32'd5;
        for (int i = 0; i < 4; i++) u_b.u_array.mem[i] = 32'd0;
        for (int i = 0; i < 512; i++) u_c.u_array.mem[i] = 32'(i);

        repeat (3) @(negedge clk);
        chk("rst_req_ready", obs(0, 0), 32'd1);
        chk("rst_rsp_valid", obs(0, 1), 32'd0);
        chk("rst_rsp_rdata", obs(0, 2), 32'd0);
        chk("rst_rsp_err",   obs(0, 3), 32'd0);

        // First acceptance on the first edge after release
        #1 rst_n = 1'b1;
        req(0, 1'b0, 10'd120, 32'd0, 32'd105, 1'b0, 3, 2, "a_load120");
        req(0, 1'b1, 10'd121, 32'd150, 32'd0, 1'b0, 3, 2, "a_store121");
        chk("a_mem121", u_a.u_array.mem[121], 32'd150);
        req(0, 1'b0, 10'd121, 32'd0, 32'd150, 1'b0, 3, 2, "a_load121");

        // Response stall: rsp_ready low for 5 response cycles, competing request held
        ifa.rsp_ready = 1'b0;
        drive(0, 1'b1, 1'b0, 10'd7, 32'd0);
        push(0, 32'hfc000000, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 10'd8, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("a_stall_vld",   obs(0, 1), 32'd1);
            chk("a_stall_rdata", obs(0, 2), 32'hfc000000);
            chk("a_stall_ready", obs(0, 0), 32'd0);
        end
        drive(0, 1'b0, 1'b0, 10'd0, 32'd0);
        @(posedge clk);
        #1 ifa.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("a_after_stall_ready", obs(0, 0), 32'd1);
        chk("a_after_stall_vld",   obs(0, 1), 32'd0);

        // Reset during WAIT drops the pending store
        drive(0, 1'b1, 1'b1, 10'd5, 32'hDEAD);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 10'd0, 32'd0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("a_rstw_req_ready", obs(0, 0), 32'd1);
        chk("a_rstw_rsp_valid", obs(0, 1), 32'd0);
        chk("a_rstw_rsp_rdata", obs(0, 2), 32'd0);
        chk("a_rstw_rsp_err",   obs(0, 3), 32'd0);
        repeat (3) @(negedge clk);
        chk("a_mem5_kept", u_a.u_array.mem[5], 32'd5);
        #1 rst_n = 1'b1;
        req(0, 1'b0, 10'd5, 32'd0, 32'd5, 1'b0, 3, 2, "a_load5");

        // Zero wait states, req_valid held high: one acceptance every 2 cycles
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 1'b1, 10'(i), 32'hB0000000 + 32'(i));
            push(1, 32'd0, 1'b0);
            @(negedge clk);
            chk("b_busy_ready", obs(1, 0), 32'd0);
            chk("b_busy_vld",   obs(1, 1), 32'd1);
            @(negedge clk);
            chk("b_idle_ready", obs(1, 0), 32'd1);
        end
        drive(1, 1'b0, 1'b0, 10'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("b_mem", u_b.u_array.mem[i], 32'hB0000000 + 32'(i));
        end
        req(1, 1'b0, 10'd2, 32'd0, 32'hB0000002, 1'b0, 1, 0, "b_load2");

        // Out-of-range and boundary addresses on the 512-word array
        req(2, 1'b0, 10'd600, 32'd0, 32'd0, 1'b1, 2, 1, "c_load600");
        req(2, 1'b1, 10'd600, 32'hBAD0BAD0, 32'd0, 1'b1, 2, 1, "c_store600");
        req(2, 1'b0, 10'd511, 32'd0, 32'd511, 1'b0, 2, 1, "c_load511");
        req(2, 1'b1, 10'd512, 32'h5555, 32'd0, 1'b1, 2, 1, "c_store512");
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (u_c.u_array.mem[i] !== 32'(i)) bad++;
        end
        chk("c_array_untouched", 32'(bad), 32'd0);

        repeat (3) @(negedge clk);
        chk("a_sb_drained", 32'(sb_a.size()), 32'd0);
        chk("b_sb_drained", 32'(sb_b.size()), 32'd0);
        chk("c_sb_drained", 32'(sb_c.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
